// File: rtl/lm_head_argmax_pkg.sv
// Shared constants, state encoding and width helpers for the tied-weight LM head argmax.
package lm_head_argmax_pkg;

    localparam int unsigned FRAC_BITS = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StCmp  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Full-precision dot-product width: product width plus growth over EMBED_DIM terms.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned embed_dim);
        return 2 * data_width + $clog2(embed_dim);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lm_head_argmax_tracker.sv
// Running argmax: holds best score/index, strict compare so ties keep the earliest index.
module lm_head_argmax_tracker #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned SCORE_W = 34
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_i,
    input  logic                      cmp_i,
    input  logic signed [SCORE_W-1:0] score_i,
    input  logic [IDX_W-1:0]          idx_i,
    output logic signed [SCORE_W-1:0] best_score_o,
    output logic [IDX_W-1:0]          best_idx_o
);

    localparam logic signed [SCORE_W-1:0] MinScore = {1'b1, {(SCORE_W - 1){1'b0}}};

    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;

    always_comb begin
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        if (init_i) begin
            best_score_d = MinScore;
            best_idx_d   = '0;
        end else if (cmp_i && (score_i > best_score_q)) begin
            best_score_d = score_i;
            best_idx_d   = idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_score_q <= '0;
            best_idx_q   <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign best_score_o = best_score_q;
    assign best_idx_o   = best_idx_q;

endmodule

// File: rtl/lm_head_argmax.sv
// Tied-weight LM head: scores every vocabulary row against the hidden vector with one
// serial MAC and reports the highest-scoring token and its score.
module lm_head_argmax
    import lm_head_argmax_pkg::*;
#(
    parameter int unsigned VOCAB_SIZE = 16,
    parameter int unsigned EMBED_DIM  = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, EMBED_DIM),
    localparam int unsigned TOK_W     = idx_width(VOCAB_SIZE),
    localparam int unsigned DIM_W     = idx_width(EMBED_DIM)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_token_emb,
    input  logic [TOK_W-1:0]                load_token_idx,
    input  logic [DIM_W-1:0]                load_dim_idx,
    input  logic [DATA_WIDTH-1:0]           load_data,
    input  logic                            valid_in,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0] hidden_in,
    output logic                            busy,
    output logic [TOK_W-1:0]                token_out,
    output logic signed [ACC_WIDTH-1:0]     max_score,
    output logic                            valid_out
);

    localparam logic [TOK_W-1:0] TokLast = TOK_W'(VOCAB_SIZE - 1);
    localparam logic [DIM_W-1:0] DimLast = DIM_W'(EMBED_DIM - 1);

    state_e state_q, state_d;

    logic start, load_en, mac_en, cmp_en, done_en;

    logic [DATA_WIDTH-1:0] token_emb_q [VOCAB_SIZE][EMBED_DIM];
    logic [DATA_WIDTH-1:0] token_emb_d [VOCAB_SIZE][EMBED_DIM];

    logic [EMBED_DIM-1:0][DATA_WIDTH-1:0] hidden_q, hidden_d;
    logic [TOK_W-1:0]                     v_q, v_d;
    logic [DIM_W-1:0]                     d_q, d_d;
    logic signed [ACC_WIDTH-1:0]          acc_q, acc_d;
    logic [TOK_W-1:0]                     token_out_q, token_out_d;
    logic signed [ACC_WIDTH-1:0]          max_score_q, max_score_d;
    logic                                 valid_out_q, valid_out_d;

    logic signed [DATA_WIDTH-1:0]   hid_elem, emb_elem;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    best_score;
    logic [TOK_W-1:0]               best_idx;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (valid_in) state_d = StMac;
            StMac:   if (d_q == DimLast) state_d = StCmp;
            StCmp:   state_d = (v_q == TokLast) ? StDone : StMac;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: decoded strobes
    always_comb begin
        busy    = (state_q != StIdle);
        start   = (state_q == StIdle) && valid_in;
        load_en = (state_q == StIdle) && load_token_emb;
        mac_en  = (state_q == StMac);
        cmp_en  = (state_q == StCmp);
        done_en = (state_q == StDone);
    end

    // Table writes only land while idle, so a running search sees a frozen table.
    always_comb begin
        token_emb_d = token_emb_q;
        if (load_en) begin
            token_emb_d[load_token_idx][load_dim_idx] = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_emb_q <= '{default: '{default: '0}};
        end else begin
            token_emb_q <= token_emb_d;
        end
    end

    always_comb begin
        hid_elem = hidden_q[d_q];
        emb_elem = token_emb_q[v_q][d_q];
        prod     = (2 * DATA_WIDTH)'(hid_elem) * (2 * DATA_WIDTH)'(emb_elem);
    end

    always_comb begin
        hidden_d    = hidden_q;
        v_d         = v_q;
        d_d         = d_q;
        acc_d       = acc_q;
        token_out_d = token_out_q;
        max_score_d = max_score_q;
        valid_out_d = 1'b0;
        if (start) begin
            hidden_d = hidden_in;
            v_d      = '0;
            d_d      = '0;
            acc_d    = '0;
        end
        if (mac_en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
            if (d_q != DimLast) begin
                d_d = d_q + 1'b1;
            end
        end
        if (cmp_en) begin
            acc_d = '0;
            d_d   = '0;
            if (v_q != TokLast) begin
                v_d = v_q + 1'b1;
            end
        end
        if (done_en) begin
            token_out_d = best_idx;
            max_score_d = best_score;
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hidden_q    <= '0;
            v_q         <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            token_out_q <= '0;
            max_score_q <= '0;
            valid_out_q <= 1'b0;
        end else begin
            hidden_q    <= hidden_d;
            v_q         <= v_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            token_out_q <= token_out_d;
            max_score_q <= max_score_d;
            valid_out_q <= valid_out_d;
        end
    end

    lm_head_argmax_tracker #(
        .IDX_W   (TOK_W),
        .SCORE_W (ACC_WIDTH)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .init_i       (start),
        .cmp_i        (cmp_en),
        .score_i      (acc_q),
        .idx_i        (v_q),
        .best_score_o (best_score),
        .best_idx_o   (best_idx)
    );

    assign token_out = token_out_q;
    assign max_score = max_score_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_lm_head_argmax.sv
// Directed bench for lm_head_argmax: vector table of searches plus busy/reset/back-to-back sequences.
module tb_lm_head_argmax;
    import lm_head_argmax_pkg::*;

    localparam int VOCAB = 16;
    localparam int DIM   = 4;
    localparam int DW    = 16;
    localparam int AW    = 34;
    localparam int LAT   = VOCAB * (DIM + 1) + 1;
    localparam logic [DW-1:0] ONE = DW'(1 << FRAC_BITS);

    localparam logic [63:0] H_A  = 64'h0000_0000_0000_0200;
    localparam logic [63:0] H_E3 = 64'h0100_0000_0000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load_token_emb;
    logic [3:0]           load_token_idx;
    logic [1:0]           load_dim_idx;
    logic [DW-1:0]        load_data;
    logic                 valid_in;
    logic [DIM*DW-1:0]    hidden_in;
    logic                 busy;
    logic [3:0]           token_out;
    logic signed [AW-1:0] max_score;
    logic                 valid_out;

    lm_head_argmax dut (
        .clk            (clk),
        .rst            (rst),
        .load_token_emb (load_token_emb),
        .load_token_idx (load_token_idx),
        .load_dim_idx   (load_dim_idx),
        .load_data      (load_data),
        .valid_in       (valid_in),
        .hidden_in      (hidden_in),
        .busy           (busy),
        .token_out      (token_out),
        .max_score      (max_score),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 setup;
        logic [63:0]        hidden;
        int                 tok;
        logic signed [63:0] score;
    } vec_t;

    vec_t vecs[6];
    int   n_pass   = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int tok, input int dim, input logic [DW-1:0] val);
        load_token_emb = 1'b1;
        load_token_idx = 4'(tok);
        load_dim_idx   = 2'(dim);
        load_data      = val;
        tick();
        load_token_emb = 1'b0;
    endtask

    task automatic setup(input int s);
        case (s)
            1: load(5, 0, ONE);
            2: for (int v = 0; v < VOCAB; v++) load(v, 0, (v == 3) ? 16'hFF80 : 16'(-(v + 1) * 256));
            3: begin
                load(2, 0, ONE);
                load(2, 1, ONE);
                load(9, 2, 16'h0400);
            end
            4: for (int d = 0; d < DIM; d++) load(15, d, 16'h8000);
            5: begin
                load(7, 0, ONE);
                load(7, 1, 16'hFF00);
                load(12, 3, 16'h0180);
            end
            default: ;
        endcase
    endtask

    // Accepting edge is the tick inside this task.
    task automatic start(input logic [63:0] h);
        valid_in  = 1'b1;
        hidden_in = h;
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!valid_out && lat < 200);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid_out) cnt++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input int tok, input logic signed [63:0] score);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " token_out"}, 64'(token_out), 64'(tok));
        check({tag, " max_score"}, 64'(max_score), score);
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0] = '{1, H_A, 5, 64'sh2_0000};
        vecs[1] = '{0, 64'h1234_8000_7FFF_0042, 0, 64'sh0};
        vecs[2] = '{2, 64'h0000_0000_0000_0100, 3, -64'sh8000};
        vecs[3] = '{3, 64'h0000_0080_0100_0100, 2, 64'sh2_0000};
        vecs[4] = '{4, 64'h8000_8000_8000_8000, 15, 64'sh1_0000_0000};
        vecs[5] = '{5, 64'h0100_0000_0100_0300, 7, 64'sh2_0000};

        rst            = 1'b1;
        load_token_emb = 1'b0;
        load_token_idx = '0;
        load_dim_idx   = '0;
        load_data      = '0;
        valid_in       = 1'b0;
        hidden_in      = '0;

        do_reset();
        check("reset busy", 64'(busy), 64'(0));
        check("reset valid_out", 64'(valid_out), 64'(0));
        check("reset token_out", 64'(token_out), 64'(0));
        check("reset max_score", 64'(max_score), 64'(0));

        for (int i = 0; i < 6; i++) begin
            do_reset();
            setup(vecs[i].setup);
            start(vecs[i].hidden);
            wait_result(lat);
            check_result($sformatf("vec%0d", i), lat, LAT, vecs[i].tok, vecs[i].score);
            tick();
            check($sformatf("vec%0d pulse width", i), 64'(valid_out), 64'(0));
            check($sformatf("vec%0d busy after", i), 64'(busy), 64'(0));
        end

        // Busy interference: stray valid_in and table write at cycle 10 must be ignored.
        do_reset();
        setup(1);
        start(H_A);
        repeat (9) tick();
        check("busy mid-search", 64'(busy), 64'(1));
        valid_in       = 1'b1;
        hidden_in      = H_E3;
        load_token_emb = 1'b1;
        load_token_idx = 4'd0;
        load_dim_idx   = 2'd0;
        load_data      = 16'h7FFF;
        tick();
        valid_in       = 1'b0;
        load_token_emb = 1'b0;
        wait_result(lat);
        check_result("interfere", lat, LAT - 10, 5, 64'sh2_0000);
        count_valid(100, cnt);
        check("interfere no second valid", 64'(cnt), 64'(0));
        start(H_A);
        wait_result(lat);
        check_result("interfere table kept", lat, LAT, 5, 64'sh2_0000);

        // Reset mid-search: outputs from the previous search must also be cleared.
        start(H_A);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset token_out", 64'(token_out), 64'(0));
        check("midreset max_score", 64'(max_score), 64'(0));
        count_valid(100, cnt);
        check("midreset no valid", 64'(cnt), 64'(0));
        start(H_A);
        wait_result(lat);
        check_result("midreset table cleared", lat, LAT, 0, 64'sh0);
        setup(1);
        start(H_A);
        wait_result(lat);
        check_result("midreset restart", lat, LAT, 5, 64'sh2_0000);

        // Back-to-back: a new request is accepted in the valid_out cycle.
        do_reset();
        setup(5);
        start(64'h0100_0000_0100_0300);
        wait_result(lat);
        check_result("b2b first", lat, LAT, 7, 64'sh2_0000);
        check("b2b idle at valid_out", 64'(busy), 64'(0));
        start(H_E3);
        wait_result(lat);
        check_result("b2b second", lat, LAT, 12, 64'sh1_8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
